// File: rtl/srl_fifo_read_ctrl.sv
// Control and registered FWFT read stage for an FIFO built on addressable shift-register storage.
// Capacity is DEPTH words in storage plus one word held in the output register.
module srl_fifo_read_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic                  srl_we,
  output logic [DATA_WIDTH-1:0] srl_din,
  output logic [ADDR_WIDTH-1:0] srl_addr,
  input  logic [DATA_WIDTH-1:0] srl_dout
);

  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH:0]   cnt;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  push;
  logic                  pop;
  logic                  load;
  logic                  cnt_zero;

  assign cnt_zero  = (cnt == '0);
  assign if_full_n = (cnt != CNT_FULL);
  assign push      = if_write & if_write_ce & if_full_n;
  assign pop       = if_read & if_read_ce & out_valid;
  // Refill the output register whenever it is empty or being consumed this cycle.
  assign load      = !cnt_zero & (!out_valid | pop);

  assign srl_we     = push;
  assign srl_din    = if_din;
  // Oldest entry sits at the deepest occupied slot; address is read before the shift lands.
  assign srl_addr   = cnt_zero ? '0 : ADDR_WIDTH'(cnt - 1'b1);
  assign if_empty_n = out_valid;
  assign if_dout    = dout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      dout_q    <= '0;
    end else begin
      cnt <= cnt + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(load);
      if (load) begin
        dout_q    <= srl_dout;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
